// File: rtl/intack_pkg.sv
// Shared types and defaults for the interrupt-acknowledge sequencer.
package intack_pkg;

  localparam int VEC_W              = 8;
  localparam int PULSE_CYCLES_DEF   = 4;
  localparam int GAP_CYCLES_DEF     = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PULSE1 = 3'd1,
    GAP    = 3'd2,
    PULSE2 = 3'd3,
    HOLD   = 3'd4
  } state_t;

endpackage

// File: rtl/intack_timer.sv
// Loadable down-counter shared by all INTA phases; done flags count==0, 0-cycle.
// Load wins over enable; the count holds at zero rather than wrapping.
module intack_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/intack_sequencer.sv
// Two-pulse INTA master: INT (2-flop synchronised under INTACK_SYNC_EN) -> vector on VEC,
// 2*PULSE+GAP cycles latency; VEC/VEC_VALID held in HOLD until VEC_READY.
module intack_sequencer
  import intack_pkg::*;
#(
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEF,
  parameter int GAP_CYCLES   = GAP_CYCLES_DEF,
  parameter int CNT_W        = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             INT,
  input  logic             INT_EN,
  output logic             INTA,
  input  logic [VEC_W-1:0] DATABUS,
  output logic [VEC_W-1:0] VEC,
  output logic             VEC_VALID,
  input  logic             VEC_READY,
  output logic             BUSY,
  output logic [7:0]       ACK_COUNT
);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  logic int_q;

`ifdef INTACK_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], INT};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign int_q = sync_q[1];
`else
  assign int_q = INT;
`endif

  state_t             state_q, state_d;
  logic               inta_q, inta_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic               vld_q, vld_d;
  logic               busy_q, busy_d;
  logic [7:0]         ack_q, ack_d;

  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_load_val;
  logic               tmr_en;
  logic               tmr_done;

  intack_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  // Once PULSE1 is entered the sequence is committed: INT and INT_EN are only looked at in IDLE.
  always_comb begin
    state_d      = state_q;
    inta_d       = inta_q;
    vec_d        = vec_q;
    vld_d        = vld_q;
    ack_d        = ack_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (int_q && INT_EN) begin
          state_d      = PULSE1;
          inta_d       = 1'b0;
          tmr_load     = 1'b1;
          tmr_load_val = PULSE_LOAD;
        end
      end
      PULSE1: begin
        if (tmr_done) begin
          state_d      = GAP;
          inta_d       = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = GAP_LOAD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      GAP: begin
        if (tmr_done) begin
          state_d      = PULSE2;
          inta_d       = 1'b0;
          tmr_load     = 1'b1;
          tmr_load_val = PULSE_LOAD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      PULSE2: begin
        if (tmr_done) begin
          state_d = HOLD;
          inta_d  = 1'b1;
          vec_d   = DATABUS;
          vld_d   = 1'b1;
          ack_d   = ack_q + 8'd1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      HOLD: begin
        if (VEC_READY) begin
          state_d = IDLE;
          vld_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        inta_d  = 1'b1;
        vld_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      inta_q  <= 1'b1;
      vec_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      inta_q  <= inta_d;
      vec_q   <= vec_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  assign INTA      = inta_q;
  assign VEC       = vec_q;
  assign VEC_VALID = vld_q;
  assign BUSY      = busy_q;
  assign ACK_COUNT = ack_q;

endmodule

// File: tb/tb_intack_sequencer.sv
// Directed bench for intack_sequencer: INTA waveform, capture, gating, backpressure, wrap, reset.
module tb_intack_sequencer;

  localparam int P = 4;
  localparam int G = 2;
`ifdef INTACK_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       INT;
  logic       INT_EN;
  logic       INTA;
  logic [7:0] DATABUS;
  logic [7:0] VEC;
  logic       VEC_VALID;
  logic       VEC_READY;
  logic       BUSY;
  logic [7:0] ACK_COUNT;

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] ack_m  = 8'd0;

  intack_sequencer #(
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G),
    .CNT_W        (4)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .INT       (INT),
    .INT_EN    (INT_EN),
    .INTA      (INTA),
    .DATABUS   (DATABUS),
    .VEC       (VEC),
    .VEC_VALID (VEC_VALID),
    .VEC_READY (VEC_READY),
    .BUSY      (BUSY),
    .ACK_COUNT (ACK_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Inputs already driven; tick k=1 is the first edge that sees them.
  // lead = tick at which INTA is first seen low; drop_at = tick after which INT is released.
  task automatic run_seq(input string tag, input int lead, input int drop_at,
                         input logic [7:0] db, input logic rdy);
    logic [31:0] wi, wv, wb, ei, ev, eb;
    logic [7:0]  vcap;
    int          cap;
    int          n;
    cap  = lead + 2*P + G;
    n    = cap + 2;
    wi   = '0; wv = '0; wb = '0; ei = '0; ev = '0; eb = '0;
    vcap = 8'h00;
    DATABUS = db;
    for (int k = 1; k <= n; k++) begin
      tick();
      wi[k] = INTA;
      wv[k] = VEC_VALID;
      wb[k] = BUSY;
      if (k == cap) vcap = VEC;
      if (k == drop_at) INT = 1'b0;
      ei[k] = !(((k >= lead) && (k < lead + P)) ||
                ((k >= lead + P + G) && (k < lead + 2*P + G)));
      ev[k] = rdy ? (k == cap) : (k >= cap);
      eb[k] = (k >= lead) && (rdy ? (k <= cap) : 1'b1);
    end
    chk({tag, "_inta_wave"}, wi, ei);
    chk({tag, "_vld_wave"},  wv, ev);
    chk({tag, "_busy_wave"}, wb, eb);
    chk({tag, "_vec"},       {24'h0, vcap}, {24'h0, db});
    ack_m = ack_m + 8'd1;
    chk({tag, "_ack"},       {24'h0, ACK_COUNT}, {24'h0, ack_m});
  endtask

  initial begin
    int         bad;
    int         starts;
    int         vlds;
    int         guard;
    int         last_v;
    int         gap;
    int         t;
    logic       prev_busy;

    RST_N = 1'b0; INT = 1'b0; INT_EN = 1'b0; DATABUS = 8'h00; VEC_READY = 1'b0;
    #12;
    chk("rst_inta", {31'h0, INTA}, 32'h1);
    chk("rst_vld",  {31'h0, VEC_VALID}, 32'h0);
    chk("rst_busy", {31'h0, BUSY}, 32'h0);
    chk("rst_vec",  {24'h0, VEC}, 32'h0);
    chk("rst_ack",  {24'h0, ACK_COUNT}, 32'h0);
    tick();
    RST_N = 1'b1;
    tick(); tick();

    // Single request; INT dropped once the sequence has started
    INT = 1'b1; INT_EN = 1'b1; VEC_READY = 1'b1;
    run_seq("single", 1 + S, 1 + S, 8'h48, 1'b1);
    tick(); tick();

    // One-cycle INT pulse still produces a full sequence
    INT = 1'b1; DATABUS = 8'h3C;
    run_seq("withdrawn", 1 + S, 1, 8'h3C, 1'b1);
    tick(); tick();

    // Gating by INT_EN
    INT = 1'b1; INT_EN = 1'b0; VEC_READY = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!INTA || BUSY) bad++;
    end
    chk("gate_idle", bad, 0);

    // Enable with core backpressure; INT kept high throughout
    INT_EN = 1'b1; VEC_READY = 1'b0;
    run_seq("bp", 1, 0, 8'hA5, 1'b0);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!VEC_VALID || (VEC != 8'hA5) || !INTA || !BUSY) bad++;
    end
    chk("bp_hold_stable", bad, 0);
    VEC_READY = 1'b1;
    tick();
    chk("bp_accept_vld",  {31'h0, VEC_VALID}, 32'h0);
    chk("bp_accept_busy", {31'h0, BUSY}, 32'h0);
    chk("bp_accept_inta", {31'h0, INTA}, 32'h1);
    tick();
    chk("bp_restart_inta", {31'h0, INTA}, 32'h0);
    INT = 1'b0;
    ack_m = ack_m + 8'd1;
    for (int k = 0; k < 2*P + G + 1; k++) tick();
    chk("bp_restart_done_busy", {31'h0, BUSY}, 32'h0);
    chk("bp_restart_ack", {24'h0, ACK_COUNT}, {24'h0, ack_m});
    tick(); tick();

    // 256 back-to-back sequences: counter wraps, one sequence per accepted vector
    INT = 1'b1; INT_EN = 1'b1; VEC_READY = 1'b1; DATABUS = 8'h11;
    starts = 0; vlds = 0; guard = 0; last_v = 0; gap = 0; t = 0;
    prev_busy = 1'b0;
    while ((starts < 256) && (guard < 6000)) begin
      tick();
      guard++; t++;
      if (BUSY && !prev_busy) starts++;
      prev_busy = BUSY;
      if (VEC_VALID) begin
        vlds++;
        if (vlds > 1) gap = t - last_v;
        last_v = t;
        if (((int'(ack_m) + vlds) % 256) == 0)
          chk("ack_wrap_zero", {24'h0, ACK_COUNT}, 32'h0);
      end
      if (starts == 256) INT = 1'b0;
    end
    chk("wrap_starts", starts, 256);
    for (int k = 0; k < 2*P + G + 6; k++) begin
      tick();
      if (VEC_VALID) vlds++;
    end
    chk("wrap_vld_count", vlds, 256);
    chk("wrap_period", gap, 2*P + G + 2);
    chk("wrap_ack", {24'h0, ACK_COUNT}, {24'h0, ack_m});
    chk("wrap_idle", {31'h0, BUSY}, 32'h0);

    // Asynchronous reset in the middle of PULSE2
    INT = 1'b1; INT_EN = 1'b1; VEC_READY = 1'b1;
    for (int k = 1; k <= 1 + S + P + G + 1; k++) begin
      tick();
      if (k == 1 + S) INT = 1'b0;
    end
    chk("rst_pre_inta", {31'h0, INTA}, 32'h0);
    #3;
    RST_N = 1'b0;
    #1;
    chk("rst_async_inta", {31'h0, INTA}, 32'h1);
    chk("rst_async_vld",  {31'h0, VEC_VALID}, 32'h0);
    chk("rst_async_ack",  {24'h0, ACK_COUNT}, 32'h0);
    chk("rst_async_busy", {31'h0, BUSY}, 32'h0);
    #2;
    RST_N = 1'b1;
    ack_m = 8'd0;
    tick(); tick();
    chk("rst_after_busy", {31'h0, BUSY}, 32'h0);
    chk("rst_after_inta", {31'h0, INTA}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
